// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the sprite move scheduler: FSM states, direction
// encodings, grid size and per-sprite start tiles.
package move_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int GRID_MAX   = 12;
  localparam int MAX_SPRITE = 8;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  // Sprite 0 is the player; the rest are ghosts.
  localparam logic [4:0] START_X [MAX_SPRITE] =
    '{5'd2, 5'd5, 5'd2, 5'd7, 5'd3, 5'd9, 5'd10, 5'd11};
  localparam logic [4:0] START_Y [MAX_SPRITE] =
    '{5'd1, 5'd6, 5'd5, 5'd7, 5'd3, 5'd9, 5'd10, 5'd11};

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Bus between the move scheduler and its environment (control, requests,
// shared wall-lookup port and sprite state).
interface move_scheduler_if #(parameter int N_SPRITE = 4);
  logic                    step_tick;
  logic [4*N_SPRITE-1:0]   req_dir;
  logic [4:0]              wall_x;
  logic [4:0]              wall_y;
  logic [3:0]              turnable;
  logic [5*N_SPRITE-1:0]   pos_x;
  logic [5*N_SPRITE-1:0]   pos_y;
  logic [4*N_SPRITE-1:0]   cur_dir;
  logic                    busy;
  logic                    done;
  logic                    overrun;

  modport master (
    output step_tick, req_dir, turnable,
    input  wall_x, wall_y, pos_x, pos_y, cur_dir, busy, done, overrun
  );

  modport slave (
    input  step_tick, req_dir, turnable,
    output wall_x, wall_y, pos_x, pos_y, cur_dir, busy, done, overrun
  );
endinterface

// File: rtl/move_scheduler_tile_step.sv
// Combinational move rule for one sprite: a valid open request wins, else keep
// travelling if open, else stay put. Edges wrap through the tunnels.
module tile_step
  import move_scheduler_pkg::*;
#(
  parameter int GRID_MAX = move_scheduler_pkg::GRID_MAX
) (
  input  logic [4:0] pos_x,
  input  logic [4:0] pos_y,
  input  logic [3:0] cur_dir,
  input  logic [3:0] req,
  input  logic [3:0] turnable,
  output logic [4:0] nxt_x,
  output logic [4:0] nxt_y,
  output logic [3:0] nxt_dir
);

  localparam logic [4:0] GMAX = 5'(GRID_MAX);

  logic       req_ok_s;
  logic       cur_ok_s;
  logic [3:0] mv_dir_s;

  assign req_ok_s = is_onehot4(req) && ((req & turnable) != 4'b0000);
  assign cur_ok_s = (cur_dir & turnable) != 4'b0000;
  assign mv_dir_s = req_ok_s ? req : (cur_ok_s ? cur_dir : DIR_NONE);
  assign nxt_dir  = req_ok_s ? req : cur_dir;

  // One-tile step in the chosen direction with wrap-around at both edges.
  always_comb begin
    nxt_x = pos_x;
    nxt_y = pos_y;
    case (mv_dir_s)
      DIR_UP:    nxt_y = (pos_y <= 5'd1) ? GMAX : pos_y - 5'd1;
      DIR_DOWN:  nxt_y = (pos_y >= GMAX) ? 5'd1 : pos_y + 5'd1;
      DIR_LEFT:  nxt_x = (pos_x <= 5'd1) ? GMAX : pos_x - 5'd1;
      DIR_RIGHT: nxt_x = (pos_x >= GMAX) ? 5'd1 : pos_x + 5'd1;
      default: begin
        nxt_x = pos_x;
        nxt_y = pos_y;
      end
    endcase
  end

endmodule

// File: rtl/move_scheduler.sv
// Sequences one movement round over all sprites through a single shared
// wall-lookup port: LOOKUP then UPDATE per sprite, in index order.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int N_SPRITE = 4,
  parameter int GRID_MAX = move_scheduler_pkg::GRID_MAX
) (
  input  logic               clk,
  input  logic               rst,
  move_scheduler_if.slave    bus
);

  localparam int IDX_W = (N_SPRITE > 1) ? $clog2(N_SPRITE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITE - 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_LOOKUP = ST_LOOKUP;
  localparam logic [1:0] S_UPDATE = ST_UPDATE;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [1:0]            state_r, next_state_s;
  logic [IDX_W-1:0]      idx_r, next_idx_s;
  logic [3:0]            turn_r;
  logic [5*N_SPRITE-1:0] pos_x_r, pos_y_r;
  logic [4*N_SPRITE-1:0] dir_r;
  logic                  busy_r, done_r, overrun_r;
  logic [4:0]            wall_x_r, wall_y_r;
  logic [4:0]            nxt_x_s, nxt_y_s;
  logic [3:0]            nxt_dir_s;

  tile_step #(.GRID_MAX(GRID_MAX)) u_tile_step (
    .pos_x    (pos_x_r[5*int'(idx_r) +: 5]),
    .pos_y    (pos_y_r[5*int'(idx_r) +: 5]),
    .cur_dir  (dir_r[4*int'(idx_r) +: 4]),
    .req      (bus.req_dir[4*int'(idx_r) +: 4]),
    .turnable (turn_r),
    .nxt_x    (nxt_x_s),
    .nxt_y    (nxt_y_s),
    .nxt_dir  (nxt_dir_s)
  );

  // Round sequencing; ticks outside IDLE never restart the round.
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (bus.step_tick) begin
          next_state_s = S_LOOKUP;
          next_idx_s   = '0;
        end else begin
          next_state_s = S_IDLE;
          next_idx_s   = idx_r;
        end
      end
      S_LOOKUP: next_state_s = S_UPDATE;
      S_UPDATE: begin
        if (idx_r == LAST_IDX) begin
          next_state_s = S_DONE;
          next_idx_s   = idx_r;
        end else begin
          next_state_s = S_LOOKUP;
          next_idx_s   = idx_r + IDX_W'(1);
        end
      end
      S_DONE: begin
        next_state_s = S_IDLE;
        next_idx_s   = '0;
      end
      default: begin
        next_state_s = S_IDLE;
        next_idx_s   = '0;
      end
    endcase
  end

  // Control registers; flags are precomputed from the next state so they are
  // registered yet aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      idx_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      wall_x_r  <= 5'd0;
      wall_y_r  <= 5'd0;
    end else begin
      state_r   <= next_state_s;
      idx_r     <= next_idx_s;
      busy_r    <= (next_state_s != S_IDLE);
      done_r    <= (next_state_s == S_DONE);
      overrun_r <= overrun_r | (bus.step_tick && (state_r != S_IDLE));
      if (next_state_s == S_LOOKUP) begin
        wall_x_r <= pos_x_r[5*int'(next_idx_s) +: 5];
        wall_y_r <= pos_y_r[5*int'(next_idx_s) +: 5];
      end else begin
        wall_x_r <= 5'd0;
        wall_y_r <= 5'd0;
      end
    end
  end

  // Sprite state: capture the wall reply, then apply the move rule to idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_r <= 4'b0000;
      dir_r  <= '0;
      for (int i = 0; i < N_SPRITE; i++) begin
        pos_x_r[5*i +: 5] <= START_X[i];
        pos_y_r[5*i +: 5] <= START_Y[i];
      end
    end else begin
      if (state_r == S_LOOKUP) begin
        turn_r <= bus.turnable;
      end
      if (state_r == S_UPDATE) begin
        pos_x_r[5*int'(idx_r) +: 5] <= nxt_x_s;
        pos_y_r[5*int'(idx_r) +: 5] <= nxt_y_s;
        dir_r[4*int'(idx_r) +: 4]   <= nxt_dir_s;
      end
    end
  end

  assign bus.wall_x  = wall_x_r;
  assign bus.wall_y  = wall_y_r;
  assign bus.pos_x   = pos_x_r;
  assign bus.pos_y   = pos_y_r;
  assign bus.cur_dir = dir_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: hand-computed sprite positions and
// directions over several rounds, round timing, overrun and mid-round reset.
module tb_move_scheduler;

  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] DN = 4'b0100;
  localparam logic [3:0] LF = 4'b0010;
  localparam logic [3:0] RT = 4'b0001;
  localparam logic [3:0] NO = 4'b0000;

  logic clk;
  logic rst;
  logic [3:0] open_r;
  int n_cmp = 0;
  int n_err = 0;

  move_scheduler_if #(.N_SPRITE(4)) bus ();

  move_scheduler #(.N_SPRITE(4), .GRID_MAX(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.turnable = open_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sp(input string tag, input int i, input int x, input int y, input int d);
    chk({tag, ".x"},   32'(bus.pos_x[5*i +: 5]),   x);
    chk({tag, ".y"},   32'(bus.pos_y[5*i +: 5]),   y);
    chk({tag, ".dir"}, 32'(bus.cur_dir[4*i +: 4]), d);
  endtask

  task automatic set_req(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
    bus.req_dir = {d3, d2, d1, d0};
  endtask

  task automatic do_round(input string tag);
    int k;
    bus.step_tick = 1'b1;
    cyc();
    bus.step_tick = 1'b0;
    k = 1;
    while (bus.done !== 1'b1 && k < 40) begin
      cyc();
      k++;
    end
    chk({tag, ".done_cycle"}, k, 9);
    cyc();
  endtask

  initial begin
    int dcount;
    rst = 1'b1;
    bus.step_tick = 1'b0;
    bus.req_dir = '0;
    open_r = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.overrun", bus.overrun, 0);
    chk("rst.wall_x", bus.wall_x, 0);
    chk("rst.wall_y", bus.wall_y, 0);
    chk_sp("rst.s0", 0, 2, 1, 0);
    chk_sp("rst.s1", 1, 5, 6, 0);
    chk_sp("rst.s2", 2, 2, 5, 0);
    chk_sp("rst.s3", 3, 7, 7, 0);
    rst = 1'b0;
    cyc();

    // Round 1: player turns right into an open tile.
    open_r = 4'b0101;
    set_req(RT, NO, LF, NO);
    do_round("r1");
    chk_sp("r1.s0", 0, 3, 1, RT);
    chk_sp("r1.s1", 1, 5, 6, 0);
    chk_sp("r1.s2", 2, 2, 5, 0);

    // Round 2: ghosts start moving up and left.
    open_r = 4'b1010;
    set_req(NO, UP, LF, NO);
    do_round("r2");
    chk_sp("r2.s0", 0, 3, 1, RT);
    chk_sp("r2.s1", 1, 5, 5, UP);
    chk_sp("r2.s2", 2, 1, 5, LF);

    // Round 3: blocked left request keeps s1 going up; 0011 is no request.
    open_r = 4'b1000;
    set_req(NO, LF, 4'b0011, NO);
    do_round("r3");
    chk_sp("r3.s1", 1, 5, 4, UP);
    chk_sp("r3.s2", 2, 1, 5, LF);
    chk_sp("r3.s0", 0, 3, 1, RT);

    // Round 4: s2 wraps from x=1 to x=12.
    open_r = 4'b0010;
    set_req(UP, NO, 4'b0011, NO);
    do_round("r4");
    chk_sp("r4.s0", 0, 3, 1, RT);
    chk_sp("r4.s1", 1, 5, 4, UP);
    chk_sp("r4.s2", 2, 12, 5, LF);

    // Round 5: player wraps from y=1 to y=12.
    open_r = 4'b1000;
    set_req(UP, NO, NO, NO);
    do_round("r5");
    chk_sp("r5.s0", 0, 3, 12, UP);
    chk_sp("r5.s1", 1, 5, 3, UP);
    chk_sp("r5.s2", 2, 12, 5, LF);

    // Round 6: s2 wraps from x=12 to x=1.
    open_r = 4'b0001;
    set_req(NO, NO, RT, DN);
    do_round("r6");
    chk_sp("r6.s2", 2, 1, 5, RT);
    chk_sp("r6.s3", 3, 7, 7, 0);
    chk_sp("r6.s0", 0, 3, 12, UP);

    // Round 7: dead end, cycle-accurate busy/done/wall port.
    open_r = 4'b0000;
    set_req(RT, RT, RT, RT);
    chk("r7.busy0", bus.busy, 0);
    bus.step_tick = 1'b1;
    cyc();
    bus.step_tick = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("r7.busy@%0d", c), bus.busy, (c <= 9) ? 1 : 0);
      chk($sformatf("r7.done@%0d", c), bus.done, (c == 9) ? 1 : 0);
      if (c == 1) begin
        chk("r7.wall_x@1", bus.wall_x, 3);
        chk("r7.wall_y@1", bus.wall_y, 12);
      end
      if (c == 2) begin
        chk("r7.wall_x@2", bus.wall_x, 0);
        chk("r7.wall_y@2", bus.wall_y, 0);
      end
      if (c == 3) begin
        chk("r7.wall_x@3", bus.wall_x, 5);
        chk("r7.wall_y@3", bus.wall_y, 3);
      end
      cyc();
    end
    chk_sp("r7.s0", 0, 3, 12, UP);
    chk_sp("r7.s3", 3, 7, 7, 0);

    // Round A: tick in the DONE cycle sets overrun, no second round.
    chk("ra.overrun0", bus.overrun, 0);
    set_req(NO, NO, NO, NO);
    dcount = 0;
    bus.step_tick = 1'b1;
    cyc();
    for (int c = 1; c <= 20; c++) begin
      if (bus.done === 1'b1) dcount++;
      bus.step_tick = (c == 9);
      cyc();
    end
    bus.step_tick = 1'b0;
    chk("ra.done_pulses", dcount, 1);
    chk("ra.overrun", bus.overrun, 1);
    chk("ra.busy", bus.busy, 0);

    rst = 1'b1;
    #1;
    chk("rst2.overrun", bus.overrun, 0);
    chk("rst2.busy", bus.busy, 0);
    chk_sp("rst2.s0", 0, 2, 1, 0);
    chk_sp("rst2.s2", 2, 2, 5, 0);
    #2;
    rst = 1'b0;
    cyc();

    // Round B: extra tick at cycle 4, reset at cycle 5 abandons the round.
    open_r = 4'b0101;
    set_req(RT, NO, NO, NO);
    bus.step_tick = 1'b1;
    cyc();
    for (int c = 1; c <= 4; c++) begin
      bus.step_tick = (c == 4);
      cyc();
    end
    bus.step_tick = 1'b0;
    chk("rb.overrun@5", bus.overrun, 1);
    chk("rb.busy@5", bus.busy, 1);
    chk("rb.s0x@5", 32'(bus.pos_x[4:0]), 3);
    rst = 1'b1;
    #1;
    chk("rb.rst.busy", bus.busy, 0);
    chk("rb.rst.done", bus.done, 0);
    chk("rb.rst.overrun", bus.overrun, 0);
    chk_sp("rb.rst.s0", 0, 2, 1, 0);
    #2;
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done === 1'b1) dcount++;
      cyc();
    end
    chk("rb.no_done", dcount, 0);
    chk("rb.idle_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter N_SPRITE, default 4, number of sprites (index 0 = player, 1..N-1 = ghosts) sharing one wall-lookup port.
REQ-002 Parameter GRID_MAX, default 12, highest legal tile coordinate; legal coordinates are 1..GRID_MAX.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 step_tick  input  1  single-cycle pulse requesting one movement round for all sprites.
REQ-006 req_dir  input  4*N_SPRITE  per-sprite requested direction, one-hot {up,down,left,right} = bits [3:0], sprite i at [4i+3:4i].
REQ-007 wall_x, wall_y  output  5 each  tile coordinate presented to the shared wall-lookup unit.
REQ-008 turnable  input  4  combinational reply for (wall_x, wall_y), same bit order as req_dir, 1 = open.
REQ-009 pos_x, pos_y  output  5*N_SPRITE each  registered sprite coordinates, sprite i at [5i+4:5i].
REQ-010 cur_dir  output  4*N_SPRITE  registered current travel direction per sprite, 4'b0000 = stopped.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 done  output  1  single-cycle pulse at round completion.
REQ-013 overrun  output  1  sticky flag, step_tick received while busy.

Function
REQ-014 FSM states IDLE, LOOKUP, UPDATE, DONE; sprite index idx counts 0..N_SPRITE-1.
REQ-015 IDLE: on step_tick go to LOOKUP with idx=0; otherwise stay.
REQ-016 LOOKUP: wall_x/wall_y = pos of sprite idx; capture turnable into a register at end of cycle; go to UPDATE.
REQ-017 UPDATE: apply move rule to sprite idx; if idx=N_SPRITE-1 go to DONE, else idx+1 and go to LOOKUP.
REQ-018 DONE: done=1 for exactly this cycle; go to IDLE.
REQ-019 Latency: step_tick sampled in cycle 0 -> done high in cycle 2*N_SPRITE+1 (cycle 9 for N=4); busy high cycles 1..2*N_SPRITE+1.
REQ-020 wall_x/wall_y shall be 0 outside LOOKUP.
REQ-021 Move rule priority 1: req is one-hot and (req & turnable)!=0 -> cur_dir=req, move one tile in req.
REQ-022 Move rule priority 2: else (cur_dir & turnable)!=0 -> keep cur_dir, move one tile in cur_dir.
REQ-023 Move rule priority 3: else position unchanged, cur_dir unchanged.
REQ-024 req_dir of zero or multiple bits set shall be treated as no request.
REQ-025 Moves: up y-1, down y+1, left x-1, right x+1.
REQ-026 Wrap-around: moving left from x=1 yields x=GRID_MAX, right from x=GRID_MAX yields x=1; same for y (tunnels).
REQ-027 req_dir is sampled in the UPDATE cycle of that sprite; changes at other times do not affect it.
REQ-028 Sprites update strictly in index order; each sprite's lookup uses positions already updated earlier in the same round.
REQ-029 step_tick while busy shall be ignored for sequencing and shall set overrun; overrun clears only on Reset.
REQ-030 step_tick in the DONE cycle is also ignored (sets overrun).

Reset
REQ-031 Reset returns FSM to IDLE, idx=0, busy=0, done=0, overrun=0, captured turnable=0, wall_x/wall_y=0, all cur_dir=0.
REQ-032 Reset loads pos_x/pos_y with package start tiles; Reset mid-round abandons the round with no partial done.

Structure
REQ-033 Shared package holds the state enum, direction one-hot constants (DIR_UP=4'b1000, DIR_DOWN=4'b0100, DIR_LEFT=4'b0010, DIR_RIGHT=4'b0001), GRID_MAX, and per-sprite start-tile arrays.
REQ-034 One sub-module, tile_step: combinational next-coordinate/next-direction for one sprite from pos, cur_dir, req, turnable.

Verification
REQ-035 Sprite0 at (2,1), req=RIGHT, stub turnable=4'b0101 -> after done sprite0 at (3,1), cur_dir=RIGHT.
REQ-036 Sprite at (5,5) cur_dir=UP, req=LEFT, turnable=4'b1000 -> moves to (5,4), cur_dir stays UP.
REQ-037 Sprite at (1,5) cur_dir=LEFT, turnable=4'b0010 -> x wraps to 12; req=4'b0011 treated as no request.
REQ-038 Dead end turnable=4'b0000 -> position and cur_dir unchanged; done at cycle 9 after tick, busy high cycles 1..9.
REQ-039 Second step_tick at cycle 4 -> overrun=1, single done pulse only; Reset asserted at cycle 5 -> IDLE, start tiles, done never pulses.
